// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Drives the shared clock/data lines through open-drain enables.
module ps2_host_tx #(
  parameter int CLKFREQ_KHZ = 16000,
  parameter int INHIBIT_US  = 120,
  parameter int TIMEOUT_US  = 15000,
  parameter int FILTER_LEN  = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit,
  input  logic       ps2clk_in,
  input  logic       ps2dat_in,
  output logic       ps2clk_oe,
  output logic       ps2dat_oe
);

  localparam int INH_CNT = CLKFREQ_KHZ * INHIBIT_US / 1000;
  localparam int TO_CNT  = CLKFREQ_KHZ * TIMEOUT_US / 1000;
  localparam int CMAX    = (TO_CNT > INH_CNT) ? TO_CNT : INH_CNT;
  localparam int CW      = $clog2(CMAX + 1);

  // cnt starts at 1 on acceptance so the clock is held exactly INH_CNT cycles
  localparam logic [CW-1:0] INH_LAST = CW'(INH_CNT - 1);
  // the error pulse lands TO_CNT cycles after the clock is released
  localparam logic [CW-1:0] TO_LAST  = CW'(TO_CNT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_BITS,
    S_ACK,
    S_WAITIDLE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state;
  logic [1:0]            clk_sync;
  logic [1:0]            dat_sync;
  logic [FILTER_LEN-1:0] clk_hist;
  logic [FILTER_LEN-1:0] dat_hist;
  logic                  clk_f;
  logic                  dat_f;
  logic                  clk_f_d;
  logic                  fall;
  logic                  to_hit;
  logic [9:0]            frame;
  logic [3:0]            bitcnt;
  logic [CW-1:0]         cnt;

  assign fall       = clk_f_d & ~clk_f;
  assign to_hit     = (cnt == TO_LAST);
  assign rx_inhibit = tx_busy;

  // two-flop synchronisers feeding a sample history per line
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_hist <= '1;
      dat_hist <= '1;
    end else begin
      clk_sync <= {clk_sync[0], ps2clk_in};
      dat_sync <= {dat_sync[0], ps2dat_in};
      clk_hist <= {clk_hist[FILTER_LEN-2:0], clk_sync[1]};
      dat_hist <= {dat_hist[FILTER_LEN-2:0], dat_sync[1]};
    end
  end

  // a level is accepted only once the whole history agrees
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_f   <= 1'b1;
      dat_f   <= 1'b1;
      clk_f_d <= 1'b1;
    end else begin
      if (&clk_hist)
        clk_f <= 1'b1;
      else if (~|clk_hist)
        clk_f <= 1'b0;
      if (&dat_hist)
        dat_f <= 1'b1;
      else if (~|dat_hist)
        dat_f <= 1'b0;
      clk_f_d <= clk_f;
    end
  end

  // transmit sequencer with registered line enables and status
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      tx_error  <= 1'b0;
      ps2clk_oe <= 1'b0;
      ps2dat_oe <= 1'b0;
      frame     <= '0;
      bitcnt    <= '0;
      cnt       <= '0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      unique case (state)
        S_IDLE: begin
          ps2clk_oe <= 1'b0;
          ps2dat_oe <= 1'b0;
          if (tx_start) begin
            frame     <= {1'b1, ~^tx_data, tx_data};
            tx_busy   <= 1'b1;
            ps2clk_oe <= 1'b1;
            cnt       <= CW'(1);
            state     <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          cnt <= cnt + 1'b1;
          if (cnt >= INH_LAST) begin
            ps2dat_oe <= 1'b1;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          ps2clk_oe <= 1'b0;
          bitcnt    <= '0;
          cnt       <= '0;
          state     <= S_BITS;
        end
        S_BITS: begin
          if (fall) begin
            ps2dat_oe <= ~frame[0];
            frame     <= {1'b0, frame[9:1]};
            bitcnt    <= bitcnt + 1'b1;
            cnt       <= '0;
            if (bitcnt == 4'd9)
              state <= S_ACK;
          end else if (to_hit) begin
            state <= S_ERROR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ACK: begin
          if (fall) begin
            cnt   <= '0;
            state <= dat_f ? S_ERROR : S_WAITIDLE;
          end else if (to_hit) begin
            state <= S_ERROR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAITIDLE: begin
          if (clk_f && dat_f)
            state <= S_DONE;
          else if (to_hit)
            state <= S_ERROR;
          else
            cnt <= cnt + 1'b1;
        end
        S_DONE: begin
          tx_done <= 1'b1;
          tx_busy <= 1'b0;
          state   <= S_IDLE;
        end
        S_ERROR: begin
          ps2clk_oe <= 1'b0;
          ps2dat_oe <= 1'b0;
          tx_error  <= 1'b1;
          tx_busy   <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 device model driving clock, checking host frames.
// Scaled clock keeps inhibit/timeout runs short.
module tb_ps2_host_tx;

  localparam int CLK_KHZ = 1600;
  localparam int INH_US  = 120;
  localparam int TO_US   = 3000;
  localparam int FL      = 8;
  localparam int INH     = CLK_KHZ * INH_US / 1000;
  localparam int TO      = CLK_KHZ * TO_US / 1000;
  localparam int H       = 64;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic       rx_inhibit;
  logic       ps2clk_in;
  logic       ps2dat_in;
  logic       ps2clk_oe;
  logic       ps2dat_oe;
  logic       dev_clk;
  logic       dev_dat;

  int checks = 0;
  int errors = 0;

  assign ps2clk_in = dev_clk & ~ps2clk_oe;
  assign ps2dat_in = dev_dat & ~ps2dat_oe;

  ps2_host_tx #(
    .CLKFREQ_KHZ(CLK_KHZ),
    .INHIBIT_US (INH_US),
    .TIMEOUT_US (TO_US),
    .FILTER_LEN (FL)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_error  (tx_error),
    .rx_inhibit(rx_inhibit),
    .ps2clk_in (ps2clk_in),
    .ps2dat_in (ps2dat_in),
    .ps2clk_oe (ps2clk_oe),
    .ps2dat_oe (ps2dat_oe)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int i);
    if (i < 8) return b[i];
    if (i == 8) return ($countones(b) % 2) == 0;
    return 1'b1;
  endfunction

  task automatic send(input logic [7:0] b);
    tx_data  = b;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    check("busy_acc", tx_busy, 1);
    check("rxinh_acc", rx_inhibit, 1);
  endtask

  task automatic dev_inhibit();
    int n;
    n = 0;
    while (!ps2clk_oe && n < 50) begin
      tick();
      n++;
    end
    check("inh_seen", ps2clk_oe, 1);
    n = 0;
    while (ps2clk_oe && n < INH + 50) begin
      tick();
      n++;
    end
    check("inh_len", n, INH);
    check("start_bit", ps2dat_oe, 1);
  endtask

  task automatic dev_bit(output logic d);
    dev_clk = 1'b0;
    tick(H);
    d = ps2dat_in;
    dev_clk = 1'b1;
    tick(H);
  endtask

  task automatic dev_bits(input logic [7:0] b, input bit poke);
    logic       d;
    logic [7:0] got;
    got = '0;
    tick(H);
    for (int i = 0; i < 10; i++) begin
      if (poke && i == 4) begin
        tx_data  = 8'h55;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
      end
      dev_bit(d);
      if (i < 8) got[i] = d;
      check($sformatf("bit%0d", i), d, exp_bit(b, i));
    end
    check("rx_byte", got, b);
    check("busy_mid", tx_busy, 1);
    check("rxinh_mid", rx_inhibit, 1);
  endtask

  task automatic finish_frame(input bit ack, input bit chain,
                              input logic [7:0] b2);
    int n;
    dev_dat = !ack;
    tick(H / 2);
    dev_clk = 1'b0;
    n = 0;
    while (!tx_done && !tx_error && n < 400) begin
      tick();
      n++;
      if (n == H) dev_clk = 1'b1;
      if (n == H + H / 2) dev_dat = 1'b1;
    end
    check("end_seen", n < 400, 1);
    check("done", tx_done, ack);
    check("error", tx_error, !ack);
    check("busy_end", tx_busy, 0);
    check("rxinh_end", rx_inhibit, 0);
    check("clkoe_end", ps2clk_oe, 0);
    check("datoe_end", ps2dat_oe, 0);
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    if (chain) begin
      send(b2);
    end else begin
      tick();
      check("one_pulse", tx_done | tx_error, 0);
      tick(H);
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] b2;
    logic       d;
    int         m;
    int         bad;

    reset_n  = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_dat  = 1'b1;
    tick(5);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_error", tx_error, 0);
    check("rst_rxinh", rx_inhibit, 0);
    check("rst_clkoe", ps2clk_oe, 0);
    check("rst_datoe", ps2dat_oe, 0);
    reset_n = 1'b1;
    tick(20);

    send(8'hED);
    dev_inhibit();
    dev_bits(8'hED, 1'b0);
    finish_frame(1'b1, 1'b0, 8'h00);

    send(8'h07);
    dev_inhibit();
    dev_bits(8'h07, 1'b0);
    finish_frame(1'b1, 1'b0, 8'h00);

    send(8'h00);
    dev_inhibit();
    dev_bits(8'h00, 1'b0);
    finish_frame(1'b1, 1'b0, 8'h00);

    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom_range(0, 255));
      send(b);
      dev_inhibit();
      dev_bits(b, 1'b0);
      finish_frame(1'b1, 1'b0, 8'h00);
    end

    b = 8'($urandom_range(0, 255));
    if (b == 8'h55) b = 8'hAA;
    send(b);
    dev_inhibit();
    dev_bits(b, 1'b1);
    finish_frame(1'b1, 1'b0, 8'h00);

    b  = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    send(b);
    dev_inhibit();
    dev_bits(b, 1'b0);
    finish_frame(1'b1, 1'b1, b2);
    dev_inhibit();
    dev_bits(b2, 1'b0);
    finish_frame(1'b1, 1'b0, 8'h00);

    b = 8'($urandom_range(0, 255));
    send(b);
    dev_inhibit();
    dev_bits(b, 1'b0);
    finish_frame(1'b0, 1'b0, 8'h00);

    send(8'hFF);
    dev_inhibit();
    m = 0;
    while (!tx_error && !tx_done && m < TO + 100) begin
      tick();
      m++;
    end
    check("to_len", m, TO);
    check("to_error", tx_error, 1);
    check("to_done", tx_done, 0);
    check("to_clkoe", ps2clk_oe, 0);
    check("to_datoe", ps2dat_oe, 0);
    tick(H);

    b = (8'($urandom_range(0, 255)) & 8'hF3) | 8'h08;
    send(b);
    dev_inhibit();
    tick(H);
    for (int i = 0; i < 3; i++) begin
      dev_bit(d);
      check($sformatf("rb_bit%0d", i), d, exp_bit(b, i));
    end
    check("pre_glitch_oe", ps2dat_oe, 1);
    for (int g = 0; g < 3; g++) begin
      dev_clk = 1'b0;
      tick(FL / 2);
      dev_clk = 1'b1;
      tick(20);
    end
    check("glitch_no_adv", ps2dat_oe, 1);
    reset_n = 1'b0;
    tick();
    check("mr_clkoe", ps2clk_oe, 0);
    check("mr_datoe", ps2dat_oe, 0);
    check("mr_busy", tx_busy, 0);
    check("mr_rxinh", rx_inhibit, 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_done || tx_error) bad++;
      tick();
    end
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (tx_done || tx_error) bad++;
      tick();
    end
    check("mr_no_pulse", bad, 0);

    b = 8'($urandom_range(0, 255));
    send(b);
    dev_inhibit();
    dev_bits(b, 1'b0);
    finish_frame(1'b1, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the other direction of the existing PS/2 keyboard receive path.
- Sends command bytes to the keyboard over the shared open-drain clkps2/dataps2 lines, e.g. 0xED plus an LED mask, or 0xFF reset.
- Sits beside the keyboard receiver in the cpc core. Runs on ck16 and drives the lines through the top-level open-drain buffers.
- Raises rx_inhibit while active so the receiver ignores traffic it generates itself.

Parameters:
CLKFREQ_KHZ, 16000, system clock frequency in kHz
INHIBIT_US, 120, duration the host holds ps2 clock low before the request-to-send
TIMEOUT_US, 15000, maximum gap allowed between device clock falling edges (also covers the first edge)
FILTER_LEN, 8, number of consecutive equal synchronised samples needed to accept a line level

Ports:
clk  in  1  system clock (ck16)
reset_n  in  1  synchronous active-low reset
tx_data  in  8  byte to send; sampled when tx_start is accepted
tx_start  in  1  one-cycle request; accepted only in IDLE
tx_busy  out  1  high from acceptance until DONE/ERROR completes
tx_done  out  1  one-cycle pulse: byte sent and ACK received
tx_error  out  1  one-cycle pulse: missing ACK or timeout
rx_inhibit  out  1  equals tx_busy; tells the receiver to discard edges
ps2clk_in  in  1  raw PS/2 clock pin level
ps2dat_in  in  1  raw PS/2 data pin level
ps2clk_oe  out  1  1 = pull PS/2 clock low, 0 = release
ps2dat_oe  out  1  1 = pull PS/2 data low, 0 = release

Behaviour:
- Reset (synchronous): state IDLE. tx_busy, tx_done, tx_error, rx_inhibit, ps2clk_oe and ps2dat_oe all 0. Filters preset to 1. Counters cleared.
- Reset mid-transfer: both lines are released on the next clk edge, and no done or error pulse is issued.
- Input conditioning: 2-FF synchroniser on each line, then a FILTER_LEN stability filter. The filtered level changes only after FILTER_LEN identical samples.
- fall = filtered clock 1->0 transition (one-cycle strobe).
- Cycle counts: inhibit count = CLKFREQ_KHZ*INHIBIT_US/1000 (1920 at defaults). Timeout count = CLKFREQ_KHZ*TIMEOUT_US/1000 (240000, 18-bit counter).
- Shift frame (10 bits) = {1 stop, odd parity, tx_data[7:0]}, LSB sent first. Parity = ~^tx_data.
- IDLE: oe outputs 0. On tx_start, latch the frame, set tx_busy and go to INHIBIT.
  - tx_start in any other state is ignored. No queueing.
- INHIBIT: ps2clk_oe=1 for inhibit count cycles. On the final cycle also set ps2dat_oe=1 (start bit), then go to REQ.
- REQ: ps2clk_oe=0, ps2dat_oe held 1. Bit counter = 0, timeout counter cleared. Go to BITS immediately.
- BITS: on each fall, ps2dat_oe <= ~frame[bitcnt], bitcnt++, timeout cleared.
  - Data bits drive low for 0 and release for 1.
  - The stop bit is released (oe=0).
  - After the fall that outputs the stop bit (10th fall), go to ACK.
- ACK: on the next fall, sample the filtered data line.
  - Data = 0: go to WAITIDLE.
  - Data = 1: go to ERROR.
- WAITIDLE: wait until filtered clock and data are both 1, then go to DONE.
- DONE: tx_done=1 for one cycle, tx_busy=0, go to IDLE. The earliest a new tx_start can be accepted is the following cycle.
- ERROR: ps2dat_oe=0, ps2clk_oe=0, tx_error=1 for one cycle, tx_busy=0, go to IDLE.
- Timeout: in BITS, ACK or WAITIDLE, if the timeout counter reaches the timeout count, go to ERROR. The counter is cleared on every fall.
- tx_done and tx_error are never asserted in the same cycle.
- A fall during INHIBIT (device noise) is ignored.

Test Plan:
- Send 0xED with a device model that clocks at 12.5 kHz, 1920 cycles after start -> ps2clk_oe high for exactly 1920 cycles; then data bits 1,0,1,1,0,1,1,1, parity 1, stop released; model ACKs low -> tx_done one pulse, tx_busy falls the same cycle.
- Send 0x07 -> parity bit 0 (data driven low on the 9th fall); send 0x00 -> parity 1 (released). The model checks received bytes and parity.
- Model never clocks after the request -> tx_error pulse exactly 240000 cycles after REQ; both oe outputs 0.
- Model omits ACK (data high at the 11th fall) -> tx_error pulse, no tx_done.
- tx_start pulsed while busy with 0x55 -> ignored; the original byte completes. tx_start in the cycle after tx_done -> accepted.
- reset_n low mid-BITS and glitch pulses shorter than FILTER_LEN cycles on ps2clk_in -> oe outputs 0 the next cycle with no done/error pulse; glitches produce no bit advance.
